// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory port: request strobe, access type, address and write data out; read data and status back.
interface mem_bus_ctrl_if;
    logic        en;
    logic        rw;
    logic [31:0] abus;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (output en, rw, abus, wdata, input  rdata, ready, err, busy);
    modport slave  (input  en, rw, abus, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: big-endian byte memory behind an IDLE/BUSY/DONE handshake; ready pulses after WAIT+1 edges counting the accept edge.
// No backpressure: requests are taken only in IDLE or DONE; defining MEM_PRELOAD_EN loads the boot image on reset.
module mem_bus_ctrl #(
    parameter int DEPTH = 128,
    parameter int WAIT  = 2
) (
    input  logic          clock,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic          r_rw, r_err;
    logic [7:0]    r_mem [DEPTH];

    logic          w_accept, w_commit, w_bad, w_rw, w_ready;
    logic [31:0]   w_addr, w_wdata;
    logic [AW-3:0] w_word;

`ifdef MEM_PRELOAD_EN
    localparam logic [31:0] BOOT [9] = '{
        32'h001F0018, 32'h002F0010, 32'h003F0014, 32'h13221000, 32'h13332000,
        32'h26FFFFF4, 32'h00000000, 32'h00000001, 32'h00000000
    };
`endif

    assign w_accept = bus.en && (r_state != ST_BUSY);
    assign w_commit = (w_state_nxt == ST_DONE);

    // With no wait states an access completes on its own accept edge, so the live request is used.
    assign w_addr  = (WAIT == 0) ? bus.abus  : r_addr;
    assign w_wdata = (WAIT == 0) ? bus.wdata : r_wdata;
    assign w_rw    = (WAIT == 0) ? bus.rw    : r_rw;

    assign w_bad  = (w_addr[1:0] != 2'b00) || (w_addr > LAST_WORD);
    assign w_word = w_addr[AW-1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_BUSY: begin
                if (r_cnt == '0) w_state_nxt = ST_DONE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: begin
                w_state_nxt = ST_IDLE;
                if (bus.en) begin
                    if (WAIT == 0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CW'(WAIT - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= bus.abus;
                r_rw    <= bus.rw;
                r_wdata <= bus.wdata;
            end
            if (w_commit) begin
                r_err <= w_bad;
                if (!w_bad && w_rw)
                    r_rdata <= {r_mem[{w_word, 2'd0}], r_mem[{w_word, 2'd1}],
                                r_mem[{w_word, 2'd2}], r_mem[{w_word, 2'd3}]};
            end
        end
    end

    // Reset leaves storage alone unless the boot image is enabled; a write cut short by reset never commits.
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef MEM_PRELOAD_EN
            for (int i = 0; i < 36; i++)
                r_mem[AW'(i)] <= BOOT[i / 4][8 * (3 - (i % 4)) +: 8];
`endif
        end else if (w_commit && !w_bad && !w_rw) begin
            r_mem[{w_word, 2'd0}] <= w_wdata[31:24];
            r_mem[{w_word, 2'd1}] <= w_wdata[23:16];
            r_mem[{w_word, 2'd2}] <= w_wdata[15:8];
            r_mem[{w_word, 2'd3}] <= w_wdata[7:0];
        end
    end

    assign w_ready   = (r_state == ST_DONE);
    assign bus.ready = w_ready;
    assign bus.err   = w_ready && r_err;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.rdata = r_rdata;
endmodule
